phase_accumulator: RTL and testbench
====================================

PHASE_ACCUMULATOR -- requirements
Module: phase_accumulator

Interface
REQ-001 Parameters: ACCUMULATOR_BITS, default 24, phase width; CLK_DIV, default 2268, system clocks per sample tick (100 MHz / 44.1 kHz).
REQ-002 clk  input  1  system clock; sole clock domain.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 tw_data  input  ACCUMULATOR_BITS  tuning word (phase increment per sample).
REQ-005 tw_valid  input  1  tuning-word offer.
REQ-006 tw_ready  output  1  tuning-word accept; transfer when tw_valid && tw_ready.
REQ-007 note_on  input  1  single-cycle note start request.
REQ-008 note_off  input  1  single-cycle note stop request.
REQ-009 accumulator  output  ACCUMULATOR_BITS  registered phase, fed to the sine LUT stage.
REQ-010 sample_tick  output  1  one-cycle pulse per sample period.
REQ-011 active  output  1  high when state is not IDLE.

Function
REQ-012 Divider counter counts 0..CLK_DIV-1 and wraps; sample_tick SHALL be high for exactly the cycle in which counter == CLK_DIV-1; it runs in every state.
REQ-013 tw_ready SHALL equal NOT pending_valid; an accepted tw_data SHALL be stored in a pending register and set pending_valid.
REQ-014 On a sample_tick with pending_valid set, active_tw SHALL load the pending word, pending_valid SHALL clear, and the same tick's addition SHALL use the new word.
REQ-015 A tw_valid/tw_ready transfer coinciding with a sample_tick SHALL land in pending and take effect on the following tick.
REQ-016 States: IDLE, RUN, STOPPING.
REQ-017 IDLE: accumulator held at 0; note_on -> RUN; note_off ignored.
REQ-018 RUN: on each sample_tick accumulator <= accumulator + active_tw modulo 2^ACCUMULATOR_BITS; note_off -> STOPPING.
REQ-019 STOPPING: accumulates as in RUN; on a tick whose addition carries out of the MSB, accumulator SHALL load 0 and state SHALL go to IDLE in the same cycle (stop at phase zero, no click).
REQ-020 STOPPING with active_tw == 0 at a tick: accumulator <= 0, state -> IDLE.
REQ-021 STOPPING + note_on -> RUN without clearing phase.
REQ-022 note_on and note_off in the same cycle: note_off SHALL take priority (RUN -> STOPPING, IDLE stays IDLE, STOPPING stays STOPPING).
REQ-023 State transitions from note_on/note_off SHALL take effect the next clock, independent of sample_tick; accumulator changes only on sample_tick or reset.
REQ-024 accumulator SHALL update one clock after the clock edge at which sample_tick is high (latency 1).

Reset
REQ-025 rst asserted SHALL immediately force: state IDLE, accumulator 0, active 0, divider counter 0, sample_tick 0, active_tw 0, pending_valid 0 (tw_ready 1).
REQ-026 Reset mid-note SHALL discard pending and active tuning words; first tick after release SHALL occur CLK_DIV clocks after reset deassertion.

Structure
REQ-027 State encoding (IDLE/RUN/STOPPING) and default ACCUMULATOR_BITS / CLK_DIV constants SHALL reside in the shared synth package, used also by the LUT stage.
REQ-028 The sample-tick divider SHALL be a sub-module named sample_tick_gen (parameter CLK_DIV, ports clk, rst, tick).

Verification (bench CLK_DIV = 4, ACCUMULATOR_BITS = 24)
REQ-029 Release reset, idle 20 clocks -> sample_tick every 4th clock, accumulator 0, active 0, tw_ready 1.
REQ-030 Load tw 0x100000, note_on -> after 3 ticks accumulator 0x300000; after 16 ticks wraps to 0x000000, stays RUN.
REQ-031 tw 0x400000, accumulator 0x800000, note_off -> tick 1 0xC00000, tick 2 carry: accumulator 0, active 0 same cycle.
REQ-032 Offer second tw while pending_valid set -> tw_ready 0, held until next tick; new word used on that tick's addition.
REQ-033 note_on and note_off same cycle in RUN -> STOPPING; in IDLE -> stays IDLE, active 0.
REQ-034 Assert rst mid-RUN at accumulator 0x5A0000 -> outputs zero asynchronously; next tick 4 clocks after release.

Source files
------------

// File: rtl/phase_accumulator_pkg.sv
// Shared synth package: DDS state encoding and default sizing.
// Used by the phase accumulator and the sine LUT stage.
package phase_accumulator_pkg;

  localparam int unsigned ACC_BITS_DEF = 24;
  localparam int unsigned CLK_DIV_DEF  = 2268;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  // Divider counter width; a divide-by-1 still needs one bit.
  function automatic int unsigned cnt_width(
    input int unsigned div
  );
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/phase_accumulator_if.sv
// Tuning-word valid/ready channel.
// master drives tw_data/tw_valid, slave returns tw_ready.
interface phase_accumulator_if #(
  parameter int unsigned W = 24
) ();

  logic [W-1:0] tw_data;
  logic         tw_valid;
  logic         tw_ready;

  modport master (
    output tw_data,
    output tw_valid,
    input  tw_ready
  );

  modport slave (
    input  tw_data,
    input  tw_valid,
    output tw_ready
  );

endinterface

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: counts 0..CLK_DIV-1, tick on the last count.
// Ports: clk, rst (async, active-high), tick (one-cycle pulse).
module sample_tick_gen
  import phase_accumulator_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Gated by rst so a divide-by-1 divider is still quiet in reset.
  assign tick = (cnt_q == LAST) && !rst;

endmodule

// File: rtl/phase_accumulator.sv
// DDS phase accumulator with note FSM and double-buffered tuning word.
// Ports: clk, rst, tw (slave channel), note_on/off, accumulator, sample_tick, active.
module phase_accumulator
  import phase_accumulator_pkg::*;
#(
  parameter int unsigned ACCUMULATOR_BITS = ACC_BITS_DEF,
  parameter int unsigned CLK_DIV          = CLK_DIV_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  phase_accumulator_if.slave          tw,
  input  logic                        note_on,
  input  logic                        note_off,
  output logic [ACCUMULATOR_BITS-1:0] accumulator,
  output logic                        sample_tick,
  output logic                        active
);

  localparam int unsigned W = ACCUMULATOR_BITS;

  typedef logic [W-1:0] word_t;

  state_t state_q;
  state_t state_d;
  word_t  acc_q;
  word_t  acc_d;
  word_t  act_tw_q;
  word_t  act_tw_d;
  word_t  pend_q;
  word_t  pend_d;
  logic   pend_vld_q;
  logic   pend_vld_d;

  word_t  inc;
  logic [W:0] sum;
  logic   carry;
  logic   fire;
  logic   swap;
  logic   stop_hit;

  sample_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (sample_tick)
  );

  // Word path: pending slot refills only when empty; it is
  // promoted on a tick and that tick already adds the new word.
  always_comb begin
    fire       = tw.tw_valid && !pend_vld_q;
    swap       = sample_tick && pend_vld_q;
    inc        = swap ? pend_q : act_tw_q;
    act_tw_d   = inc;
    pend_d     = fire ? tw.tw_data : pend_q;
    pend_vld_d = fire | (pend_vld_q & ~sample_tick);
    sum        = {1'b0, acc_q} + {1'b0, inc};
    carry      = sum[W];
  end

  // Stop on phase wrap (zero crossing) or on a dead word.
  assign stop_hit = sample_tick && (carry || (inc == '0));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        acc_d = '0;
        if (note_on && !note_off) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (sample_tick) begin
          acc_d = sum[W-1:0];
        end
        if (note_off) begin
          state_d = STOPPING;
        end
      end
      STOPPING: begin
        if (sample_tick) begin
          acc_d = sum[W-1:0];
        end
        if (note_on && !note_off) begin
          state_d = RUN;
        end else if (stop_hit) begin
          acc_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        acc_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      act_tw_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      act_tw_q   <= act_tw_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  assign tw.tw_ready  = !pend_vld_q;
  assign accumulator  = acc_q;
  assign active       = (state_q != IDLE);

endmodule

// File: tb/tb_phase_accumulator.sv
// Scoreboard bench for phase_accumulator (CLK_DIV=4, 24-bit phase).
// Directed vectors push expected tick results; a monitor pops and compares.
module tb_phase_accumulator;

  logic        clk;
  logic        rst;
  logic        note_on;
  logic        note_off;
  logic [23:0] accumulator;
  logic        sample_tick;
  logic        active;
  logic        tick_prev;

  typedef struct {
    logic [23:0] acc;
    logic        act;
  } exp_t;

  exp_t sbq[$];
  int   n_chk;
  int   n_fail;

  phase_accumulator_if #(.W(24)) tw_if ();

  phase_accumulator #(
    .ACCUMULATOR_BITS (24),
    .CLK_DIV          (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tw          (tw_if),
    .note_on     (note_on),
    .note_off    (note_off),
    .accumulator (accumulator),
    .sample_tick (sample_tick),
    .active      (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) tick_prev <= sample_tick;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic void push_exp(input logic [23:0] a,
                                   input logic act);
    exp_t e;
    e.acc = a;
    e.act = act;
    sbq.push_back(e);
  endfunction

  // Called at a negedge; returns at the negedge where tick is high.
  task automatic wait_tick_neg();
    int k;
    k = 0;
    while (!sample_tick && k < 16) begin
      @(negedge clk);
      k++;
    end
    if (!sample_tick) chk("tick_timeout", 0, 1);
  endtask

  task automatic step_tick(input logic [23:0] a, input logic act);
    wait_tick_neg();
    push_exp(a, act);
    @(negedge clk);
  endtask

  // Monitor: after every tick edge, compare against the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (tick_prev && sbq.size() > 0) begin
        #1;
        e = sbq.pop_front();
        chk("sb_acc", {8'h0, accumulator}, {8'h0, e.acc});
        chk("sb_active", {31'h0, active}, {31'h0, e.act});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int first;
    int last;
    int nt;
    int gap_ok;
    int k;
    n_chk          = 0;
    n_fail         = 0;
    rst            = 1'b1;
    note_on        = 1'b0;
    note_off       = 1'b0;
    tw_if.tw_valid = 1'b0;
    tw_if.tw_data  = '0;

    // Reset state
    #12;
    chk("rst_acc", {8'h0, accumulator}, 0);
    chk("rst_active", {31'h0, active}, 0);
    chk("rst_ready", {31'h0, tw_if.tw_ready}, 1);
    chk("rst_tick", {31'h0, sample_tick}, 0);

    // Idle 20 clocks: tick every 4th clock
    @(negedge clk);
    rst    = 1'b0;
    first  = -1;
    last   = -1;
    nt     = 0;
    gap_ok = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sample_tick) begin
        if (first < 0) first = i;
        else if (i - last != 4) gap_ok = 0;
        last = i;
        nt++;
      end
      if (accumulator != 0 || active) gap_ok = 0;
    end
    chk("first_tick", first, 3);
    chk("tick_count", nt, 5);
    chk("tick_gap_idle", gap_ok, 1);
    chk("idle_ready", {31'h0, tw_if.tw_ready}, 1);

    // tw 0x100000, note_on: 3 ticks -> 0x300000, 16 -> wrap
    wait_tick_neg();
    @(negedge clk);
    tw_if.tw_data  = 24'h100000;
    tw_if.tw_valid = 1'b1;
    @(negedge clk);
    tw_if.tw_valid = 1'b0;
    note_on        = 1'b1;
    @(negedge clk);
    note_on = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step_tick(24'(i * 24'h100000), 1'b1);
    end
    chk("wrap_active", {31'h0, active}, 1);

    // Climb to 0x800000, then tw 0x400000 + note_off
    for (int i = 1; i <= 8; i++) begin
      step_tick(24'(i * 24'h100000), 1'b1);
    end
    tw_if.tw_data  = 24'h400000;
    tw_if.tw_valid = 1'b1;
    @(negedge clk);
    tw_if.tw_valid = 1'b0;
    note_off       = 1'b1;
    @(negedge clk);
    note_off = 1'b0;
    step_tick(24'hC00000, 1'b1);
    step_tick(24'h000000, 1'b0);
    step_tick(24'h000000, 1'b0);

    // Pending full: second word back-pressured until tick
    note_on        = 1'b1;
    tw_if.tw_data  = 24'h010000;
    tw_if.tw_valid = 1'b1;
    @(negedge clk);
    note_on       = 1'b0;
    tw_if.tw_data = 24'h020000;
    chk("pend_ready_c1", {31'h0, tw_if.tw_ready}, 0);
    @(negedge clk);
    chk("pend_ready_c2", {31'h0, tw_if.tw_ready}, 0);
    wait_tick_neg();
    chk("pend_ready_tick", {31'h0, tw_if.tw_ready}, 0);
    push_exp(24'h010000, 1'b1);
    @(negedge clk);
    chk("pend_ready_after", {31'h0, tw_if.tw_ready}, 1);
    @(negedge clk);
    tw_if.tw_valid = 1'b0;
    chk("pend_ready_refill", {31'h0, tw_if.tw_ready}, 0);
    step_tick(24'h030000, 1'b1);

    // Transfer on the tick edge lands in pending
    wait_tick_neg();
    tw_if.tw_data  = 24'h001000;
    tw_if.tw_valid = 1'b1;
    chk("tick_xfer_ready", {31'h0, tw_if.tw_ready}, 1);
    push_exp(24'h050000, 1'b1);
    @(negedge clk);
    tw_if.tw_valid = 1'b0;
    step_tick(24'h051000, 1'b1);

    // STOPPING + note_on -> RUN keeps phase
    note_off = 1'b1;
    @(negedge clk);
    note_off = 1'b0;
    note_on  = 1'b1;
    @(negedge clk);
    note_on = 1'b0;
    step_tick(24'h052000, 1'b1);

    // on+off in RUN -> STOPPING; zero word then stops at 0
    tw_if.tw_data  = 24'h000000;
    tw_if.tw_valid = 1'b1;
    note_on        = 1'b1;
    note_off       = 1'b1;
    @(negedge clk);
    tw_if.tw_valid = 1'b0;
    note_on        = 1'b0;
    note_off       = 1'b0;
    chk("both_run_active", {31'h0, active}, 1);
    step_tick(24'h000000, 1'b0);

    // on+off in IDLE -> stays IDLE
    note_on  = 1'b1;
    note_off = 1'b1;
    @(negedge clk);
    note_on  = 1'b0;
    note_off = 1'b0;
    chk("both_idle_active", {31'h0, active}, 0);
    step_tick(24'h000000, 1'b0);

    // Reset mid-RUN at 0x5A0000 with a word pending
    tw_if.tw_data  = 24'h2D0000;
    tw_if.tw_valid = 1'b1;
    note_on        = 1'b1;
    @(negedge clk);
    tw_if.tw_valid = 1'b0;
    note_on        = 1'b0;
    step_tick(24'h2D0000, 1'b1);
    step_tick(24'h5A0000, 1'b1);
    tw_if.tw_data  = 24'h111111;
    tw_if.tw_valid = 1'b1;
    @(negedge clk);
    tw_if.tw_valid = 1'b0;
    chk("pre_rst_ready", {31'h0, tw_if.tw_ready}, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_acc", {8'h0, accumulator}, 0);
    chk("arst_active", {31'h0, active}, 0);
    chk("arst_ready", {31'h0, tw_if.tw_ready}, 1);
    chk("arst_tick", {31'h0, sample_tick}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    k   = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sample_tick && k < 16);
    chk("tick_after_rst", k, 3);
    push_exp(24'h000000, 1'b0);
    @(negedge clk);
    note_on = 1'b1;
    @(negedge clk);
    note_on = 1'b0;
    step_tick(24'h000000, 1'b1);
    step_tick(24'h000000, 1'b1);

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
